lcd_fb_writer: RTL and testbench

- Captures the console LCD pixel bus and writes pixels into the 36-bit framebuffer RAM that the HDMI image generator reads.
- Packs 3 pixels per word in column-split layout: word at `lineBase+i` holds pixel i in [35:24], pixel COLLEN+i in [23:12], pixel 2*COLLEN+i in [11:0].
- Writes through a RAM port with per-12-bit-lane enables. No read-modify-write.

---
 rtl/lcd_fb_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_lcd_fb_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_writer.sv
// rtl/lcd_fb_writer.sv - LCD pixel bus capture into the 36-bit column-split framebuffer RAM
//
// Purpose:
//   Synchronizes the console LCD pixel bus into the clk domain. Each accepted
//   pixel is written into the framebuffer that the HDMI image generator reads.
//   Three pixels share one 36-bit word. The word at lineBase+i holds:
//     pixel i          in [35:24]
//     pixel COLLEN+i   in [23:12]
//     pixel 2*COLLEN+i in [11:0]
//   Each write drives the pixel into all three lanes, and a one-hot lane enable
//   selects the lane that is stored. No read-modify-write is needed.
//
// Optional feature (macro FBW_DROP_CNT_EN):
//   defined   - dropCnt counts dropped pixel strobes. It saturates at 16'hFFFF
//               and clears only on rst.
//   undefined - dropCnt is tied to zero.
//
// Ports:
//   clk         in   system clock (more than 4x lcdDclk)
//   rst         in   asynchronous active-high reset
//   lcdDclk     in   LCD pixel clock (async); a pixel is valid on its rising edge
//   lcdHsync    in   line sync (async); a rising edge starts a new line
//   lcdVsync    in   frame sync (async); a rising edge starts a new frame
//   lcdData     in   pixel {R[3:0],G[3:0],B[3:0]}
//   fbAddr      out  RAM write address
//   fbData      out  RAM write data (pixel replicated into 3 lanes)
//   fbWe        out  one-cycle RAM write strobe
//   fbLaneEn    out  lane enables: bit2=[35:24], bit1=[23:12], bit0=[11:0]
//   frameStart  out  one-cycle pulse on each accepted vsync
//   lineCnt     out  current line index
//   dropCnt     out  dropped pixel count (optional feature)
module lcd_fb_writer #(
    parameter int COLLEN      = 75,
    parameter int PIXELS      = 224,
    parameter int LINES       = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcdDclk,
    input  logic        lcdHsync,
    input  logic        lcdVsync,
    input  logic [11:0] lcdData,
    output logic [13:0] fbAddr,
    output logic [35:0] fbData,
    output logic        fbWe,
    output logic [2:0]  fbLaneEn,
    output logic        frameStart,
    output logic [7:0]  lineCnt,
    output logic [15:0] dropCnt
);

    localparam int CW = $clog2(COLLEN);
    localparam int XW = $clog2(PIXELS + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLLEN - 1);
    localparam logic [XW-1:0] PIX_N      = XW'(PIXELS);
    localparam logic [7:0]    LINE_LAST  = 8'(LINES - 1);
    localparam logic [13:0]   LINE_STEP  = 14'(COLLEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_dclk_sync;
    logic [SYNC_STAGES-1:0] r_hs_sync;
    logic [SYNC_STAGES-1:0] r_vs_sync;
    // The data path has one more stage than the control path. The extra stage
    // matches the registered edge detector, so the pixel that leaves the last
    // stage belongs to the dclk event that is presented in the same cycle.
    logic [11:0]            r_data_sync [SYNC_STAGES+1];

    logic r_dclk_d;
    logic r_hs_d;
    logic r_vs_d;
    logic r_dclk_e;
    logic r_hs_e;
    logic r_vs_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dclk_sync <= '0;
            r_hs_sync   <= '0;
            r_vs_sync   <= '0;
            for (int i = 0; i <= SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
            r_dclk_d <= 1'b0;
            r_hs_d   <= 1'b0;
            r_vs_d   <= 1'b0;
            r_dclk_e <= 1'b0;
            r_hs_e   <= 1'b0;
            r_vs_e   <= 1'b0;
        end else begin
            r_dclk_sync[0] <= lcdDclk;
            r_hs_sync[0]   <= lcdHsync;
            r_vs_sync[0]   <= lcdVsync;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dclk_sync[i] <= r_dclk_sync[i-1];
                r_hs_sync[i]   <= r_hs_sync[i-1];
                r_vs_sync[i]   <= r_vs_sync[i-1];
            end
            r_data_sync[0] <= lcdData;
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_dclk_d <= r_dclk_sync[SYNC_STAGES-1];
            r_hs_d   <= r_hs_sync[SYNC_STAGES-1];
            r_vs_d   <= r_vs_sync[SYNC_STAGES-1];
            r_dclk_e <= r_dclk_sync[SYNC_STAGES-1] & ~r_dclk_d;
            r_hs_e   <= r_hs_sync[SYNC_STAGES-1]   & ~r_hs_d;
            r_vs_e   <= r_vs_sync[SYNC_STAGES-1]   & ~r_vs_d;
        end
    end

    // ------------------------------------------------------------------
    // Event arbitration: vsync beats hsync beats dclk
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [CW-1:0] r_col;
    logic [1:0]    r_lane;
    logic [13:0]   r_line_base;
    logic [7:0]    r_line_cnt;

    logic [13:0]   r_addr;
    logic [35:0]   r_data;
    logic          r_we;
    logic [2:0]    r_lane_en;
    logic          r_frame_start;

    logic w_hs;
    logic w_dclk;
    logic w_line_adv;
    logic w_wr;

    assign w_hs       = r_hs_e & ~r_vs_e;
    assign w_dclk     = r_dclk_e & ~r_hs_e & ~r_vs_e;
    // Hsyncs that arrive before any pixel of the line (blanking) are ignored.
    assign w_line_adv = w_hs & (r_state == S_ACTIVE) & (r_x != '0);
    assign w_wr       = w_dclk & (r_state == S_ACTIVE) & (r_x < PIX_N);

    // ------------------------------------------------------------------
    // Line/frame state machine and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_col         <= '0;
            r_lane        <= '0;
            r_line_base   <= '0;
            r_line_cnt    <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_we          <= 1'b0;
            r_lane_en     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_we          <= 1'b0;
            r_lane_en     <= '0;
            r_frame_start <= 1'b0;

            if (r_vs_e) begin
                // A vsync starts a new frame from any state, including recovery from BLANK.
                r_state       <= S_ACTIVE;
                r_x           <= '0;
                r_col         <= '0;
                r_lane        <= '0;
                r_line_base   <= '0;
                r_line_cnt    <= '0;
                r_frame_start <= 1'b1;
            end else if (w_line_adv) begin
                r_line_cnt  <= r_line_cnt + 8'd1;
                r_line_base <= r_line_base + LINE_STEP;
                r_x         <= '0;
                r_col       <= '0;
                r_lane      <= '0;
                if (r_line_cnt == LINE_LAST) begin
                    r_state <= S_BLANK;
                end
            end else if (w_wr) begin
                r_addr    <= r_line_base + 14'(r_col);
                r_data    <= {3{r_data_sync[SYNC_STAGES]}};
                r_lane_en <= 3'b100 >> r_lane;
                r_we      <= 1'b1;
                r_x       <= r_x + 1'b1;
                // Column wraps into the next 12-bit lane of the same words.
                if (r_col == COL_LAST) begin
                    r_col  <= '0;
                    r_lane <= r_lane + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign fbAddr     = r_addr;
    assign fbData     = r_data;
    assign fbWe       = r_we;
    assign fbLaneEn   = r_lane_en;
    assign frameStart = r_frame_start;
    assign lineCnt    = r_line_cnt;

    // ------------------------------------------------------------------
    // Dropped-pixel counter
    // ------------------------------------------------------------------
`ifdef FBW_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // A dclk event is dropped when no write is issued for it. This covers
    // three cases: it lost arbitration, the state was not ACTIVE, or it was
    // past the end of the line.
    assign w_drop = r_dclk_e & ~w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign dropCnt = r_drop_cnt;
`else
    assign dropCnt = '0;
`endif

endmodule

// File: tb/tb_lcd_fb_writer.sv
// tb/tb_lcd_fb_writer.sv - scoreboard bench for lcd_fb_writer with a frame-level reference model
module tb_lcd_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcdDclk;
    logic        lcdHsync;
    logic        lcdVsync;
    logic [11:0] lcdData;
    logic [13:0] fbAddr;
    logic [35:0] fbData;
    logic        fbWe;
    logic [2:0]  fbLaneEn;
    logic        frameStart;
    logic [7:0]  lineCnt;
    logic [15:0] dropCnt;

    always #5 clk = ~clk;

    lcd_fb_writer dut (
        .clk        (clk),
        .rst        (rst),
        .lcdDclk    (lcdDclk),
        .lcdHsync   (lcdHsync),
        .lcdVsync   (lcdVsync),
        .lcdData    (lcdData),
        .fbAddr     (fbAddr),
        .fbData     (fbData),
        .fbWe       (fbWe),
        .fbLaneEn   (fbLaneEn),
        .frameStart (frameStart),
        .lineCnt    (lineCnt),
        .dropCnt    (dropCnt)
    );

    typedef struct {
        logic [13:0] addr;
        logic [2:0]  en;
        logic [35:0] data;
    } wr_t;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    wr_t wlog[$];
    wr_t mon_e;
    wr_t mon_g;
    int  fs_cnt = 0;
    int  wr_cnt = 0;

    // Reference model: frame position in plain pixel/line terms.
    int m_mode = 0;   // 0 idle, 1 active, 2 blank
    int m_x = 0;
    int m_line = 0;
    int m_frames = 0;
    int m_drops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef FBW_DROP_CNT_EN
        return (m_drops > 65535) ? 65535 : m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic m_vs();
        m_mode = 1;
        m_x = 0;
        m_line = 0;
        m_frames++;
    endtask

    task automatic m_hs();
        if (m_mode == 1 && m_x > 0) begin
            m_line++;
            m_x = 0;
            if (m_line == 144) m_mode = 2;
        end
    endtask

    task automatic m_dclk(input logic [11:0] p);
        wr_t w;
        if (m_mode == 1 && m_x < 224) begin
            w.addr = 14'(m_line * 75 + m_x % 75);
            w.en   = 3'(3'b100 >> (m_x / 75));
            w.data = {p, p, p};
            exp_q.push_back(w);
            m_x++;
        end else begin
            m_drops++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pixel(input logic [11:0] p);
        lcdData = p;
        tick(1);
        lcdDclk = 1'b1;
        m_dclk(p);
        tick(2);
        lcdDclk = 1'b0;
        tick(2);
    endtask

    task automatic hsync();
        lcdHsync = 1'b1;
        m_hs();
        tick(3);
        lcdHsync = 1'b0;
        tick(2);
    endtask

    task automatic vsync();
        lcdVsync = 1'b1;
        m_vs();
        tick(3);
        lcdVsync = 1'b0;
        tick(2);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick(1);
            n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  64'(fbAddr), 64'd0);
        check({tag, "_data"},  64'(fbData), 64'd0);
        check({tag, "_we"},    64'(fbWe), 64'd0);
        check({tag, "_lane"},  64'(fbLaneEn), 64'd0);
        check({tag, "_fs"},    64'(frameStart), 64'd0);
        check({tag, "_line"},  64'(lineCnt), 64'd0);
        check({tag, "_drop"},  64'(dropCnt), 64'd0);
    endtask

    // Monitor: pops an expected write every time the RAM port strobes.
    always @(negedge clk) begin
        if (frameStart) fs_cnt++;
        if (fbWe) begin
            mon_g.addr = fbAddr;
            mon_g.en   = fbLaneEn;
            mon_g.data = fbData;
            wlog.push_back(mon_g);
            wr_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr=%0d lane=%b, required no write", fbAddr, fbLaneEn);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(fbAddr), 64'(mon_e.addr));
                check("wr_lane", 64'(fbLaneEn), 64'(mon_e.en));
                check("wr_data", 64'(fbData), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;
        int f0;
        int l0;
        wr_t tmp;

        rst      = 1'b1;
        lcdDclk  = 1'b0;
        lcdHsync = 1'b0;
        lcdVsync = 1'b0;
        lcdData  = '0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(3);

        // One line, pixel value = x.
        vsync();
        wlog.delete();
        for (int x = 0; x < 224; x++) pixel(12'(x));
        drain();
        check("line1_writes", 64'(wlog.size()), 64'd224);
        if (wlog.size() == 224) begin
            tmp = wlog[0];
            check("x0_addr", 64'(tmp.addr), 64'd0);
            check("x0_lane", 64'(tmp.en), 64'b100);
            tmp = wlog[75];
            check("x75_addr", 64'(tmp.addr), 64'd0);
            check("x75_lane", 64'(tmp.en), 64'b010);
            check("x75_data", 64'(tmp.data), 64'h04B04B04B);
            tmp = wlog[223];
            check("x223_addr", 64'(tmp.addr), 64'd73);
            check("x223_lane", 64'(tmp.en), 64'b001);
        end

        // Two more hsync-separated lines, then a new frame.
        hsync();
        for (int x = 0; x < 224; x++) pixel(12'($urandom));
        hsync();
        wlog.delete();
        for (int x = 0; x < 224; x++) pixel(12'($urandom));
        drain();
        if (wlog.size() > 0) begin
            tmp = wlog[0];
            check("line2_addr", 64'(tmp.addr), 64'd150);
        end else begin
            check("line2_writes", 64'(wlog.size()), 64'd224);
        end
        check("line2_linecnt", 64'(lineCnt), 64'd2);
        f0 = fs_cnt;
        vsync();
        check("vs_linecnt", 64'(lineCnt), 64'd0);
        check("vs_frame_pulse", 64'(fs_cnt - f0), 64'd1);
        wlog.delete();
        pixel(12'($urandom));
        drain();
        check("vs_next_writes", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) begin
            tmp = wlog[0];
            check("vs_next_addr", 64'(tmp.addr), 64'd0);
        end

        // 146 lines: the last two fall into blanking.
        vsync();
        d0 = int'(dropCnt);
        w0 = wr_cnt;
        for (int l = 0; l < 146; l++) begin
            hsync();
            for (int x = 0; x < ((l < 144) ? 2 : 224); x++) pixel(12'($urandom));
        end
        drain();
        check("blank_linecnt", 64'(lineCnt), 64'd144);
        check("blank_writes", 64'(wr_cnt - w0), 64'd288);
        check("blank_dropcnt", 64'(dropCnt), 64'(exp_drop()));
`ifdef FBW_DROP_CNT_EN
        check("blank_drop_delta", 64'(int'(dropCnt) - d0), 64'd448);
`endif

        // Overlong line.
        vsync();
        hsync();
        d0 = int'(dropCnt);
        w0 = wr_cnt;
        for (int x = 0; x < 240; x++) pixel(12'($urandom));
        drain();
        check("long_writes", 64'(wr_cnt - w0), 64'd224);
        check("long_dropcnt", 64'(dropCnt), 64'(exp_drop()));
`ifdef FBW_DROP_CNT_EN
        check("long_drop_delta", 64'(int'(dropCnt) - d0), 64'd16);
`endif

        // vsync and dclk coincident.
        d0 = int'(dropCnt);
        w0 = wr_cnt;
        f0 = fs_cnt;
        lcdData  = 12'($urandom);
        lcdVsync = 1'b1;
        lcdDclk  = 1'b1;
        m_vs();
        m_drops++;
        tick(3);
        lcdVsync = 1'b0;
        lcdDclk  = 1'b0;
        tick(4);
        check("vsdclk_frame", 64'(fs_cnt - f0), 64'd1);
        check("vsdclk_writes", 64'(wr_cnt - w0), 64'd0);
        check("vsdclk_dropcnt", 64'(dropCnt), 64'(exp_drop()));
        for (int x = 0; x < 5; x++) pixel(12'($urandom));
        drain();

        // hsync and dclk coincident.
        w0 = wr_cnt;
        l0 = int'(lineCnt);
        lcdData  = 12'($urandom);
        lcdHsync = 1'b1;
        lcdDclk  = 1'b1;
        m_hs();
        m_drops++;
        tick(3);
        lcdHsync = 1'b0;
        lcdDclk  = 1'b0;
        tick(4);
        check("hsdclk_line", 64'(lineCnt), 64'(l0 + 1));
        check("hsdclk_writes", 64'(wr_cnt - w0), 64'd0);
        check("hsdclk_dropcnt", 64'(dropCnt), 64'(exp_drop()));
        pixel(12'($urandom));
        drain();

        // Reset mid-line.
        vsync();
        for (int x = 0; x < 100; x++) pixel(12'($urandom));
        drain();
        tick(3);
        rst = 1'b1;
        exp_q.delete();
        m_mode  = 0;
        m_x     = 0;
        m_line  = 0;
        m_drops = 0;
        tick(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        w0 = wr_cnt;
        for (int x = 0; x < 10; x++) pixel(12'($urandom));
        tick(4);
        check("idle_writes", 64'(wr_cnt - w0), 64'd0);
        check("idle_dropcnt", 64'(dropCnt), 64'(exp_drop()));
        vsync();
        wlog.delete();
        pixel(12'($urandom));
        drain();
        check("postrst_writes", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) begin
            tmp = wlog[0];
            check("postrst_addr", 64'(tmp.addr), 64'd0);
        end

        tick(5);
        check("frame_pulses", 64'(fs_cnt), 64'(m_frames));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
